// File: rtl/rom_scanner_if.sv
// Bus bundle between rom_scanner and its surroundings: scan command, ROM port and result stream.
// The optional max output exists only when ROM_SCANNER_MAX_EN is defined.
interface rom_scanner_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 12
);
  logic              start;
  logic [ADDR_W-1:0] first;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic [SUM_W-1:0]  sum;
`ifdef ROM_SCANNER_MAX_EN
  logic [DATA_W-1:0] max;
`endif
  logic              done;

  // Handshake: start is a level sampled only while the scanner is idle (busy=0, done=0);
  // word_valid qualifies word for exactly one cycle, done is a one-cycle completion pulse.
  modport master (
    input  start, first, count, rom_data,
`ifdef ROM_SCANNER_MAX_EN
    output max,
`endif
    output rom_addr, busy, word_valid, word, sum, done
  );

  modport slave (
    output start, first, count, rom_data,
`ifdef ROM_SCANNER_MAX_EN
    input  max,
`endif
    input  rom_addr, busy, word_valid, word, sum, done
  );
endinterface

// File: rtl/rom_scanner.sv
// Walks a wrap-around range of ROM addresses, absorbs the one-cycle ROM latency and streams/sums the words.
// Optional running maximum enabled by defining ROM_SCANNER_MAX_EN.
module rom_scanner #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_scanner_if.master bus,
  output logic [1:0]    o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W:0]   r_left;
  logic [ADDR_W:0]   w_eff_n;
  logic              r_issue_d;
  logic              r_word_valid;
  logic [DATA_W-1:0] r_word;
  logic [SUM_W-1:0]  r_sum;
  logic              w_start_ok;
  logic              w_issue;
  logic              w_busy;
  logic              w_done;

  assign w_eff_n = (bus.count > CNT_FULL) ? CNT_FULL : bus.count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (w_eff_n == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (r_left == CNT_ONE) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_ok = 1'b0;
    w_issue    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE:  w_start_ok = bus.start;
      S_ISSUE: begin
        w_issue = 1'b1;
        w_busy  = 1'b1;
      end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Address is loaded on the accepting edge so cycle 1 already presents `first`; the last
  // issued address is kept rather than advanced past the range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_left     <= '0;
    end else if (w_start_ok && (w_eff_n != '0)) begin
      r_rom_addr <= bus.first;
      r_left     <= w_eff_n;
    end else if (w_issue) begin
      r_left <= r_left - CNT_ONE;
      if (r_left != CNT_ONE) r_rom_addr <= r_rom_addr + ADDR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_d    <= 1'b0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
      r_sum        <= '0;
    end else begin
      r_issue_d    <= w_issue;
      r_word_valid <= r_issue_d;
      if (w_start_ok) begin
        r_sum <= '0;
      end else if (r_issue_d) begin
        r_word <= bus.rom_data;
        r_sum  <= r_sum + {{(SUM_W-DATA_W){1'b0}}, bus.rom_data};
      end
    end
  end

`ifdef ROM_SCANNER_MAX_EN
  logic [DATA_W-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
    end else if (w_start_ok) begin
      r_max <= '0;
    end else if (r_issue_d && (bus.rom_data > r_max)) begin
      r_max <= bus.rom_data;
    end
  end

  assign bus.max = r_max;
`endif

  assign bus.rom_addr   = r_rom_addr;
  assign bus.busy       = w_busy;
  assign bus.word_valid = r_word_valid;
  assign bus.word       = r_word;
  assign bus.sum        = r_sum;
  assign bus.done       = w_done;
  assign o_dbg_state    = r_state;
endmodule
